// File: rtl/ila_sig_sync_filt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ila_sig_sync_filt_pkg
// Description : Shared defaults, edge-pulse type and parameter-range helper
//               for the ILA probe-signal conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
package ila_sig_sync_filt_pkg;

    localparam int ILA_SYNC_STAGES_DEF = 2;
    localparam int ILA_FILT_W_DEF      = 4;
    localparam int ILA_FILT_CNT_DEF    = 1;

    typedef struct packed {
        logic rise;
        logic fall;
    } edge_t;

    function automatic bit filt_cnt_ok(input int cnt, input int w);
        return (cnt >= 1) && (cnt <= ((1 << w) - 1));
    endfunction

endpackage : ila_sig_sync_filt_pkg
`default_nettype wire

// File: rtl/ila_sig_sync_ch.sv
`default_nettype none
// ============================================================================
// Module      : ila_sig_sync_ch
// Description : One conditioner channel: synchroniser, stability filter and
//               registered edge detector. Optional sticky edge flag when
//               ILA_SIG_SYNC_STICKY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module ila_sig_sync_ch
    import ila_sig_sync_filt_pkg::*;
#(
    parameter int STAGES   = ILA_SYNC_STAGES_DEF,
    parameter int FILT_W   = ILA_FILT_W_DEF,
    parameter int FILT_CNT = ILA_FILT_CNT_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_data,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
`ifdef ILA_SIG_SYNC_STICKY_EN
    ,
    input  logic i_sticky_clr,
    output logic o_sticky
`endif
);

    localparam logic [FILT_W-1:0] c_TERM = FILT_W'(FILT_CNT - 1);

    logic [STAGES-1:0] r_sync;
    logic [FILT_W-1:0] r_cnt;
    logic              r_level;
    edge_t             r_edge;
    logic              w_sy;

    assign w_sy = r_sync[STAGES-1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_edge  <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_data};
            // Any cycle agreeing with the current level restarts the count.
            if (!i_en || (w_sy == r_level)) begin
                r_cnt  <= '0;
                r_edge <= '0;
            end else if (r_cnt == c_TERM) begin
                r_level     <= w_sy;
                r_cnt       <= '0;
                r_edge.rise <= w_sy;
                r_edge.fall <= ~w_sy;
            end else begin
                r_cnt  <= r_cnt + FILT_W'(1);
                r_edge <= '0;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_edge.rise;
    assign o_fall  = r_edge.fall;

`ifdef ILA_SIG_SYNC_STICKY_EN
    logic r_sticky;

    // A pulse arriving together with the clear keeps the flag set.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sticky <= 1'b0;
        end else begin
            r_sticky <= (r_sticky & ~i_sticky_clr) | r_edge.rise | r_edge.fall;
        end
    end

    assign o_sticky = r_sticky;
`endif

endmodule : ila_sig_sync_ch
`default_nettype wire

// File: rtl/ila_sig_sync_filt.sv
`default_nettype none
// ============================================================================
// Module      : ila_sig_sync_filt
// Description : W-channel synchronise / glitch-filter / edge-detect front end
//               for ILA probes. Sticky edge flags enabled by the macro
//               ILA_SIG_SYNC_STICKY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ila_sig_sync_filt
    import ila_sig_sync_filt_pkg::*;
#(
    parameter int W        = 1,
    parameter int STAGES   = ILA_SYNC_STAGES_DEF,
    parameter int FILT_W   = ILA_FILT_W_DEF,
    parameter int FILT_CNT = ILA_FILT_CNT_DEF
) (
    input  logic         clk_i,
    input  logic         arst_i,
    input  logic         en_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic [W-1:0] rise_o,
    output logic [W-1:0] fall_o
`ifdef ILA_SIG_SYNC_STICKY_EN
    ,
    input  logic         sticky_clr_i,
    output logic [W-1:0] sticky_o
`endif
);

    if (STAGES < 2) begin : g_bad_stages
        $error("ila_sig_sync_filt: STAGES must be >= 2");
    end
    if (!filt_cnt_ok(FILT_CNT, FILT_W)) begin : g_bad_filt_cnt
        $error("ila_sig_sync_filt: FILT_CNT out of range for FILT_W");
    end

    for (genvar gi = 0; gi < W; gi++) begin : g_ch
        ila_sig_sync_ch #(
            .STAGES   (STAGES),
            .FILT_W   (FILT_W),
            .FILT_CNT (FILT_CNT)
        ) u_ch (
            .i_clk        (clk_i),
            .i_rst        (arst_i),
            .i_en         (en_i),
            .i_data       (data_i[gi]),
            .o_level      (data_o[gi]),
            .o_rise       (rise_o[gi]),
            .o_fall       (fall_o[gi])
`ifdef ILA_SIG_SYNC_STICKY_EN
            ,
            .i_sticky_clr (sticky_clr_i),
            .o_sticky     (sticky_o[gi])
`endif
        );
    end

endmodule : ila_sig_sync_filt
`default_nettype wire

// File: tb/tb_ila_sig_sync_filt.sv
`default_nettype none
// ============================================================================
// Module      : tb_ila_sig_sync_filt
// Description : Self-checking bench: three conditioner instances with
//               different STAGES/FILT_CNT against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ila_sig_sync_filt;

    logic       clk  = 1'b0;
    logic       arst = 1'b1;
    logic       en   = 1'b1;
    logic       clr  = 1'b0;
    logic [3:0] din [3];
    logic [3:0] q_d [3];
    logic [3:0] q_r [3];
    logic [3:0] q_f [3];
`ifdef ILA_SIG_SYNC_STICKY_EN
    logic [3:0] q_s [3];
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instance 0: STAGES=2 FILT_CNT=1; 1: STAGES=2 FILT_CNT=5; 2: STAGES=3 FILT_CNT=8
    ila_sig_sync_filt #(.W(4), .STAGES(2), .FILT_W(4), .FILT_CNT(1)) u_d0 (
        .clk_i(clk), .arst_i(arst), .en_i(en), .data_i(din[0]),
        .data_o(q_d[0]), .rise_o(q_r[0]), .fall_o(q_f[0])
`ifdef ILA_SIG_SYNC_STICKY_EN
        , .sticky_clr_i(clr), .sticky_o(q_s[0])
`endif
    );
    ila_sig_sync_filt #(.W(4), .STAGES(2), .FILT_W(4), .FILT_CNT(5)) u_d1 (
        .clk_i(clk), .arst_i(arst), .en_i(en), .data_i(din[1]),
        .data_o(q_d[1]), .rise_o(q_r[1]), .fall_o(q_f[1])
`ifdef ILA_SIG_SYNC_STICKY_EN
        , .sticky_clr_i(clr), .sticky_o(q_s[1])
`endif
    );
    ila_sig_sync_filt #(.W(4), .STAGES(3), .FILT_W(4), .FILT_CNT(8)) u_d2 (
        .clk_i(clk), .arst_i(arst), .en_i(en), .data_i(din[2]),
        .data_o(q_d[2]), .rise_o(q_r[2]), .fall_o(q_f[2])
`ifdef ILA_SIG_SYNC_STICKY_EN
        , .sticky_clr_i(clr), .sticky_o(q_s[2])
`endif
    );

    // Behavioural reference: delay line of raw samples, run-length of
    // disagreement against the held level, flip when the run reaches FILT_CNT.
    int         STG [3] = '{2, 2, 3};
    int         FC  [3] = '{1, 5, 8};
    logic [3:0] m_pipe [3][3];
    int         m_run  [3][4];
    logic [3:0] m_lvl [3];
    logic [3:0] m_ris [3];
    logic [3:0] m_fal [3];
    logic [3:0] m_stk [3];

    always @(posedge clk or posedge arst) begin
        logic [3:0] sy;
        if (arst) begin
            for (int d = 0; d < 3; d++) begin
                m_lvl[d] = '0; m_ris[d] = '0; m_fal[d] = '0; m_stk[d] = '0;
                for (int k = 0; k < 3; k++) m_pipe[d][k] = '0;
                for (int c = 0; c < 4; c++) m_run[d][c] = 0;
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                m_stk[d] = (m_stk[d] & ~{4{clr}}) | m_ris[d] | m_fal[d];
                sy = m_pipe[d][STG[d]-1];
                m_ris[d] = '0;
                m_fal[d] = '0;
                for (int c = 0; c < 4; c++) begin
                    if (!en || sy[c] == m_lvl[d][c]) begin
                        m_run[d][c] = 0;
                    end else begin
                        m_run[d][c] = m_run[d][c] + 1;
                        if (m_run[d][c] == FC[d]) begin
                            m_lvl[d][c] = sy[c];
                            m_run[d][c] = 0;
                            if (sy[c]) m_ris[d][c] = 1'b1;
                            else       m_fal[d][c] = 1'b1;
                        end
                    end
                end
                for (int k = 2; k > 0; k--) m_pipe[d][k] = m_pipe[d][k-1];
                m_pipe[d][0] = din[d];
            end
        end
    end

    task automatic test_reset();
        din[0] = 4'hF; din[1] = 4'hF; din[2] = 4'hF;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({q_d[d], q_r[d], q_f[d]} !== 12'h000) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: got d=%b r=%b f=%b, expected all 0", d, q_d[d], q_r[d], q_f[d]);
            end
`ifdef ILA_SIG_SYNC_STICKY_EN
            checks++;
            if (q_s[d] !== 4'h0) begin
                errors++;
                $display("FAIL reset_sticky dut%0d: got %b, expected 0000", d, q_s[d]);
            end
`endif
        end
        arst = 1'b0;
        din[0] = 4'b1010; din[1] = 4'h0; din[2] = 4'h0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if (q_d[0] !== ((k >= 3) ? 4'b1010 : 4'b0000)) begin
                errors++;
                $display("FAIL release_data edge%0d: got %b, expected %b", k, q_d[0], (k >= 3) ? 4'b1010 : 4'b0000);
            end
            checks++;
            if (q_r[0] !== ((k == 3) ? 4'b1010 : 4'b0000) || q_f[0] !== 4'b0000) begin
                errors++;
                $display("FAIL release_edges edge%0d: got r=%b f=%b, expected r=%b f=0000", k, q_r[0], q_f[0], (k == 3) ? 4'b1010 : 4'b0000);
            end
        end
    endtask

    task automatic test_filter();
        din[1] = 4'b0001;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            checks++;
            if (q_d[1][0] !== 1'b0 || q_r[1][0] !== 1'b0) begin
                errors++;
                $display("FAIL glitch_blocked cyc%0d: got d=%b r=%b, expected 0 0", k, q_d[1][0], q_r[1][0]);
            end
            if (k == 4) din[1] = 4'b0000;
        end
        din[1] = 4'b0001;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            checks++;
            if (q_d[1][0] !== (k >= 7 && k <= 11) || q_r[1][0] !== (k == 7) || q_f[1][0] !== (k == 12)) begin
                errors++;
                $display("FAIL pulse5 edge%0d: got d=%b r=%b f=%b, expected d=%b r=%b f=%b", k,
                         q_d[1][0], q_r[1][0], q_f[1][0], (k >= 7 && k <= 11), (k == 7), (k == 12));
            end
            if (k == 5) din[1] = 4'b0000;
        end
    endtask

    task automatic test_enable();
        en = 1'b0;
        din[1] = 4'b0010;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            checks++;
            if (q_d[1][1] !== 1'b0 || (q_r[0] | q_r[1] | q_r[2] | q_f[0] | q_f[1] | q_f[2]) !== 4'h0) begin
                errors++;
                $display("FAIL enable_frozen cyc%0d: got d1=%b r1=%b f1=%b, expected frozen 0 and no pulses", k, q_d[1][1], q_r[1], q_f[1]);
            end
        end
        en = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checks++;
            if (q_d[1][1] !== (k >= 5) || q_r[1][1] !== (k == 5)) begin
                errors++;
                $display("FAIL enable_resume edge%0d: got d=%b r=%b, expected d=%b r=%b", k, q_d[1][1], q_r[1][1], (k >= 5), (k == 5));
            end
        end
    endtask

    task automatic test_reset_mid();
        din[2] = 4'b0001;
        repeat (9) @(negedge clk);
        #2 arst = 1'b1;
        #1;
        checks++;
        if ({q_d[0], q_d[1], q_d[2], q_r[1], q_r[2]} !== 20'h0) begin
            errors++;
            $display("FAIL async_clear: got d0=%b d1=%b d2=%b, expected all 0", q_d[0], q_d[1], q_d[2]);
        end
        @(negedge clk);
        arst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            checks++;
            if (q_d[2][0] !== (k >= 11) || q_r[2][0] !== (k == 11)) begin
                errors++;
                $display("FAIL reset_mid edge%0d: got d=%b r=%b, expected d=%b r=%b", k, q_d[2][0], q_r[2][0], (k >= 11), (k == 11));
            end
            checks++;
            if (q_f[0] !== 4'h0) begin
                errors++;
                $display("FAIL reset_no_fall edge%0d: got f=%b, expected 0000", k, q_f[0]);
            end
        end
    endtask

`ifdef ILA_SIG_SYNC_STICKY_EN
    task automatic test_sticky();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (q_s[0] !== 4'h0) begin
            errors++;
            $display("FAIL sticky_clear_all: got %b, expected 0000", q_s[0]);
        end
        din[0] = 4'b1110;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checks++;
            if (q_r[0][2] !== (k == 3) || q_s[0][2] !== (k >= 4)) begin
                errors++;
                $display("FAIL sticky_set edge%0d: got r=%b s=%b, expected r=%b s=%b", k, q_r[0][2], q_s[0][2], (k == 3), (k >= 4));
            end
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (q_s[0][2] !== 1'b0) begin
            errors++;
            $display("FAIL sticky_clr: got %b, expected 0", q_s[0][2]);
        end
        din[0] = 4'b1010;
        repeat (3) @(negedge clk);
        checks++;
        if (q_f[0][2] !== 1'b1) begin
            errors++;
            $display("FAIL sticky_fall_pulse: got %b, expected 1", q_f[0][2]);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (q_s[0][2] !== 1'b1) begin
            errors++;
            $display("FAIL sticky_edge_wins: got %b, expected 1", q_s[0][2]);
        end
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (q_d[d] !== m_lvl[d] || q_r[d] !== m_ris[d] || q_f[d] !== m_fal[d]) begin
                    errors++;
                    $display("FAIL random dut%0d cyc%0d: got d=%b r=%b f=%b, expected d=%b r=%b f=%b",
                             d, n, q_d[d], q_r[d], q_f[d], m_lvl[d], m_ris[d], m_fal[d]);
                end
                checks++;
                if ((q_r[d] & q_f[d]) !== 4'h0) begin
                    errors++;
                    $display("FAIL rise_and_fall dut%0d cyc%0d: got %b, expected 0000", d, n, q_r[d] & q_f[d]);
                end
`ifdef ILA_SIG_SYNC_STICKY_EN
                checks++;
                if (q_s[d] !== m_stk[d]) begin
                    errors++;
                    $display("FAIL random_sticky dut%0d cyc%0d: got %b, expected %b", d, n, q_s[d], m_stk[d]);
                end
`endif
                if ($urandom_range(0, 3) == 0)
                    din[d] = din[d] ^ 4'($urandom & $urandom);
                else if ($urandom_range(0, 31) == 0)
                    din[d] = 4'($urandom);
            end
            en  = ($urandom_range(0, 15) != 0);
            clr = ($urandom_range(0, 7) == 0);
        end
        en  = 1'b1;
        clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_filter();
        test_enable();
        test_reset_mid();
`ifdef ILA_SIG_SYNC_STICKY_EN
        test_sticky();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_ila_sig_sync_filt
`default_nettype wire
